// File: rtl/control_sequencer.sv
// ---------------------------------------------------------------------------
// control_sequencer
//
// Microcoded control unit for the 8-bit bus CPU. A free-running divider on the
// fast system clock produces a one-cycle microstep strobe (tick). The
// sequencer walks each instruction through microsteps T0..T4 and decodes the
// current microstep, opcode and ALU flags into a 16-bit control word that
// drives the datapath bus enables and register loads.
//
// Parameters
//   TICK_DIV    clk cycles per microstep (>= 2)
//
// Ports
//   clk         in   system clock, all state changes on the rising edge
//   reset       in   synchronous, active-high reset
//   opcode      in   [3:0] IR[7:4] from the datapath instruction register
//   carry_flag  in   latched ALU carry (used by JC)
//   zero_flag   in   latched ALU zero  (used by JZ)
//   run         in   1 = free-running ticks, 0 = paused
//   step_req    in   level; each rising edge while paused requests one tick
//   tick        out  one-clk microstep strobe
//   ctrl        out  [15:0] control word, stable for the whole microstep
//   step        out  [2:0] current microstep 0..4
//   halted      out  HLT executed; sticky until reset
// ---------------------------------------------------------------------------
module control_sequencer #(
  parameter int unsigned TICK_DIV = 890000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  opcode,
  input  logic        carry_flag,
  input  logic        zero_flag,
  input  logic        run,
  input  logic        step_req,
  output logic        tick,
  output logic [15:0] ctrl,
  output logic [2:0]  step,
  output logic        halted
);

  // Divider width; TICK_DIV >= 2 so at least one bit is needed.
  localparam int unsigned CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  // Control word bit masks.
  localparam logic [15:0] PC_IN     = 16'h0001;
  localparam logic [15:0] PC_OUT    = 16'h0002;
  localparam logic [15:0] PC_ADD    = 16'h0004;
  localparam logic [15:0] MAR_IN    = 16'h0008;
  localparam logic [15:0] RAM_IN    = 16'h0010;
  localparam logic [15:0] RAM_OUT   = 16'h0020;
  localparam logic [15:0] IR_IN     = 16'h0040;
  localparam logic [15:0] IR_OUT    = 16'h0080;
  localparam logic [15:0] A_IN      = 16'h0100;
  localparam logic [15:0] A_OUT     = 16'h0200;
  localparam logic [15:0] B_IN      = 16'h0400;
  localparam logic [15:0] ALU_OUT   = 16'h0800;
  localparam logic [15:0] ALU_SUB   = 16'h1000;
  localparam logic [15:0] FLAGS_IN  = 16'h2000;
  localparam logic [15:0] OUTPUT_IN = 16'h4000;
  localparam logic [15:0] HALT      = 16'h8000;

  // Opcodes.
  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_LDA = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_OUT = 4'd3;
  localparam logic [3:0] OP_SUB = 4'd4;
  localparam logic [3:0] OP_STA = 4'd5;
  localparam logic [3:0] OP_LDI = 4'd6;
  localparam logic [3:0] OP_JMP = 4'd7;
  localparam logic [3:0] OP_JC  = 4'd8;
  localparam logic [3:0] OP_JZ  = 4'd9;
  localparam logic [3:0] OP_HLT = 4'd15;

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4
  } step_t;

  // Final microstep of each opcode; the step after it wraps back to T0.
  // Unassigned opcodes behave as NOP and end after the fetch.
  function automatic logic [2:0] last_step_of(input logic [3:0] op);
    case (op)
      OP_LDA, OP_STA:                         last_step_of = 3'd3;
      OP_ADD, OP_SUB:                         last_step_of = 3'd4;
      OP_OUT, OP_LDI, OP_JMP, OP_JC, OP_JZ,
      OP_HLT:                                 last_step_of = 3'd2;
      default:                                last_step_of = 3'd1;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  step_t            step_reg, step_next;
  logic             halted_reg, halted_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             step_req_sync_reg;   // step_req registered once
  logic             step_req_prev_reg;   // previous value for edge detection
  logic             single_pulse_reg, single_pulse_next;

  // Constant lookup table of last microsteps, one entry per opcode.
  logic [15:0][2:0] last_step_tbl;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_last_step
      assign last_step_tbl[gi] = last_step_of(4'(gi));
    end
  endgenerate

  logic       div_tick;
  logic       step_req_rise;
  logic [2:0] last_step;
  logic       at_last_step;

  assign div_tick      = (count_reg == CNT_LAST);
  assign step_req_rise = step_req_sync_reg & ~step_req_prev_reg;
  assign last_step     = last_step_tbl[opcode];
  // >= rather than == so that any out-of-range step always recovers to T0.
  assign at_last_step  = (3'(step_reg) >= last_step);

  // While running, only the divider can tick; a pending single-step pulse is
  // dropped if run rises before it fires. Nothing ticks once halted.
  assign tick = ~halted_reg & (run ? div_tick : single_pulse_reg);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    count_next        = div_tick ? '0 : count_reg + 1'b1;
    // Edges seen while running or halted are discarded, never queued.
    single_pulse_next = step_req_rise & ~run & ~halted_reg;
    step_next         = step_reg;
    halted_next       = halted_reg;

    if (tick) begin
      if (at_last_step) begin
        step_next = T0;
      end else begin
        step_next = step_t'(3'(step_reg) + 3'd1);
      end
      if ((step_reg == T2) && (opcode == OP_HLT)) begin
        halted_next = 1'b1;
        step_next   = T0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      step_reg          <= T0;
      halted_reg        <= 1'b0;
      count_reg         <= '0;
      step_req_sync_reg <= 1'b0;
      step_req_prev_reg <= 1'b0;
      single_pulse_reg  <= 1'b0;
    end else begin
      step_reg          <= step_next;
      halted_reg        <= halted_next;
      count_reg         <= count_next;
      step_req_sync_reg <= step_req;
      step_req_prev_reg <= step_req_sync_reg;
      single_pulse_reg  <= single_pulse_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Control word decode. Depends only on registered step plus the datapath's
  // IR and flags, so it is stable for the whole microstep. During the fetch
  // steps the opcode is ignored because IR still holds the previous
  // instruction until the T1 tick.
  // ---------------------------------------------------------------------------
  logic [15:0] ctrl_word;

  always_comb begin
    ctrl_word = '0;
    if (!halted_reg) begin
      case (step_reg)
        T0: ctrl_word = PC_OUT | MAR_IN;
        T1: ctrl_word = RAM_OUT | IR_IN | PC_ADD;
        T2: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: ctrl_word = IR_OUT | MAR_IN;
            OP_OUT: ctrl_word = A_OUT | OUTPUT_IN;
            OP_LDI: ctrl_word = IR_OUT | A_IN;
            OP_JMP: ctrl_word = IR_OUT | PC_IN;
            OP_JC:  ctrl_word = carry_flag ? (IR_OUT | PC_IN) : 16'h0000;
            OP_JZ:  ctrl_word = zero_flag  ? (IR_OUT | PC_IN) : 16'h0000;
            OP_HLT: ctrl_word = HALT;
            default: ctrl_word = 16'h0000;
          endcase
        end
        T3: begin
          case (opcode)
            OP_LDA:         ctrl_word = RAM_OUT | A_IN;
            OP_ADD, OP_SUB: ctrl_word = RAM_OUT | B_IN;
            OP_STA:         ctrl_word = A_OUT | RAM_IN;
            default:        ctrl_word = 16'h0000;
          endcase
        end
        T4: begin
          case (opcode)
            OP_ADD:  ctrl_word = ALU_OUT | A_IN | FLAGS_IN;
            OP_SUB:  ctrl_word = ALU_OUT | ALU_SUB | A_IN | FLAGS_IN;
            default: ctrl_word = 16'h0000;
          endcase
        end
        default: ctrl_word = 16'h0000;
      endcase
    end
  end

  assign ctrl   = ctrl_word;
  assign step   = step_reg;
  assign halted = halted_reg;

  // OP_NOP is documented for readability; it shares the default decode path.
  logic unused_ok;
  assign unused_ok = &{1'b0, OP_NOP};

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

  localparam int TD = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  opcode;
  logic        carry_flag;
  logic        zero_flag;
  logic        run;
  logic        step_req;
  logic        tick;
  logic [15:0] ctrl;
  logic [2:0]  step;
  logic        halted;

  int n_checks = 0;
  int n_errors = 0;

  control_sequencer #(.TICK_DIV(TD)) dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .carry_flag (carry_flag),
    .zero_flag  (zero_flag),
    .run        (run),
    .step_req   (step_req),
    .tick       (tick),
    .ctrl       (ctrl),
    .step       (step),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one clock and sample just after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Wait for the next tick (bounded) and check its latency and the microstep
  // it lands on.
  task automatic do_tick(input string tag, input int exp_lat,
                         input logic [2:0] exp_step, input logic [15:0] exp_ctrl);
    int n;
    n = 0;
    do begin
      cyc();
      n++;
    end while (tick !== 1'b1 && n < 100);
    check({tag, ".lat"}, n, exp_lat);
    check({tag, ".step"}, {29'd0, step}, {29'd0, exp_step});
    check({tag, ".ctrl"}, {16'd0, ctrl}, {16'd0, exp_ctrl});
    $display("tick %s: after %0d cycles step=%0d ctrl=%04h", tag, n, step, ctrl);
  endtask

  // After the last tick of an instruction: step back at T0, then present the
  // next opcode (as IR would, well before the T1 tick).
  task automatic next_instr(input string tag, input logic [3:0] op);
    cyc();
    check({tag, ".start_step"}, {29'd0, step}, 32'd0);
    opcode = op;
  endtask

  int n_ticks;
  int n_lat;

  initial begin
    reset = 1'b1; run = 1'b1; opcode = 4'd1;
    carry_flag = 1'b0; zero_flag = 1'b0; step_req = 1'b0;
    cyc();
    cyc();
    check("rst.tick",   {31'd0, tick},   32'd0);
    check("rst.ctrl",   {16'd0, ctrl},   32'h000A);
    check("rst.step",   {29'd0, step},   32'd0);
    check("rst.halted", {31'd0, halted}, 32'd0);
    reset = 1'b0;

    // LDA
    do_tick("lda.t0", 3, 3'd0, 16'h000A);
    do_tick("lda.t1", 4, 3'd1, 16'h0064);
    do_tick("lda.t2", 4, 3'd2, 16'h0088);
    do_tick("lda.t3", 4, 3'd3, 16'h0120);

    next_instr("add", 4'd2);
    do_tick("add.t0", 3, 3'd0, 16'h000A);
    do_tick("add.t1", 4, 3'd1, 16'h0064);
    do_tick("add.t2", 4, 3'd2, 16'h0088);
    do_tick("add.t3", 4, 3'd3, 16'h0420);
    do_tick("add.t4", 4, 3'd4, 16'h2900);

    next_instr("sub", 4'd4);
    do_tick("sub.t0", 3, 3'd0, 16'h000A);
    do_tick("sub.t1", 4, 3'd1, 16'h0064);
    do_tick("sub.t2", 4, 3'd2, 16'h0088);
    do_tick("sub.t3", 4, 3'd3, 16'h0420);
    do_tick("sub.t4", 4, 3'd4, 16'h3900);

    next_instr("jc0", 4'd8);
    carry_flag = 1'b0;
    do_tick("jc0.t0", 3, 3'd0, 16'h000A);
    do_tick("jc0.t1", 4, 3'd1, 16'h0064);
    do_tick("jc0.t2", 4, 3'd2, 16'h0000);

    next_instr("jc1", 4'd8);
    carry_flag = 1'b1;
    do_tick("jc1.t0", 3, 3'd0, 16'h000A);
    do_tick("jc1.t1", 4, 3'd1, 16'h0064);
    do_tick("jc1.t2", 4, 3'd2, 16'h0081);

    next_instr("jz1", 4'd9);
    carry_flag = 1'b0;
    zero_flag  = 1'b1;
    do_tick("jz1.t0", 3, 3'd0, 16'h000A);
    do_tick("jz1.t1", 4, 3'd1, 16'h0064);
    do_tick("jz1.t2", 4, 3'd2, 16'h0081);

    next_instr("sta", 4'd5);
    zero_flag = 1'b0;
    do_tick("sta.t0", 3, 3'd0, 16'h000A);
    do_tick("sta.t1", 4, 3'd1, 16'h0064);
    do_tick("sta.t2", 4, 3'd2, 16'h0088);
    do_tick("sta.t3", 4, 3'd3, 16'h0210);

    next_instr("out", 4'd3);
    do_tick("out.t0", 3, 3'd0, 16'h000A);
    do_tick("out.t1", 4, 3'd1, 16'h0064);
    do_tick("out.t2", 4, 3'd2, 16'h4200);

    next_instr("ldi", 4'd6);
    do_tick("ldi.t0", 3, 3'd0, 16'h000A);
    do_tick("ldi.t1", 4, 3'd1, 16'h0064);
    do_tick("ldi.t2", 4, 3'd2, 16'h0180);

    next_instr("jmp", 4'd7);
    do_tick("jmp.t0", 3, 3'd0, 16'h000A);
    do_tick("jmp.t1", 4, 3'd1, 16'h0064);
    do_tick("jmp.t2", 4, 3'd2, 16'h0081);

    next_instr("nop", 4'd0);
    do_tick("nop.t0", 3, 3'd0, 16'h000A);
    do_tick("nop.t1", 4, 3'd1, 16'h0064);

    next_instr("op12", 4'd12);
    do_tick("op12.t0", 3, 3'd0, 16'h000A);
    do_tick("op12.t1", 4, 3'd1, 16'h0064);

    // HLT
    next_instr("hlt", 4'd15);
    do_tick("hlt.t0", 3, 3'd0, 16'h000A);
    do_tick("hlt.t1", 4, 3'd1, 16'h0064);
    do_tick("hlt.t2", 4, 3'd2, 16'h8000);
    cyc();
    check("hlt.halted", {31'd0, halted}, 32'd1);
    check("hlt.ctrl",   {16'd0, ctrl},   32'd0);
    check("hlt.step",   {29'd0, step},   32'd0);
    n_ticks = 0;
    for (int i = 0; i < 100; i++) begin
      if (i == 50) run = 1'b0;
      step_req = ((i % 10) < 3) ? 1'b1 : 1'b0;
      cyc();
      if (tick === 1'b1) n_ticks++;
    end
    step_req = 1'b0;
    check("hlt.no_ticks", n_ticks, 0);
    check("hlt.still_halted", {31'd0, halted}, 32'd1);
    check("hlt.step_frozen", {29'd0, step}, 32'd0);
    $display("halt window: %0d ticks in 100 cycles", n_ticks);
    reset = 1'b1;
    cyc();
    check("hltrst.halted", {31'd0, halted}, 32'd0);
    check("hltrst.step",   {29'd0, step},   32'd0);
    check("hltrst.ctrl",   {16'd0, ctrl},   32'h000A);
    opcode = 4'd1;
    reset  = 1'b0;

    // Pause: run=0 since before reset release.
    n_ticks = 0;
    for (int i = 0; i < 3 * TD; i++) begin
      cyc();
      if (tick === 1'b1) n_ticks++;
    end
    check("pause.no_ticks", n_ticks, 0);

    // Single-step: three pulses.
    for (int k = 0; k < 3; k++) begin
      check("sstep.pre_step", {29'd0, step}, k);
      step_req = 1'b1;
      n_lat = 0;
      do begin
        cyc();
        n_lat++;
      end while (tick !== 1'b1 && n_lat < 20);
      check("sstep.lat", n_lat, 2);
      step_req = 1'b0;
      cyc();
      check("sstep.post_step", {29'd0, step}, k + 1);
      n_ticks = 0;
      for (int i = 0; i < 6; i++) begin
        cyc();
        if (tick === 1'b1) n_ticks++;
      end
      check("sstep.single", n_ticks, 0);
      $display("single step %0d: latency %0d, step now %0d", k, n_lat, step);
    end

    // Holding step_req high gives only one tick.
    step_req = 1'b1;
    n_ticks = 0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (tick === 1'b1) n_ticks++;
    end
    step_req = 1'b0;
    check("hold.ticks", n_ticks, 1);
    check("hold.step", {29'd0, step}, 32'd0);
    $display("step_req held: %0d ticks in 12 cycles", n_ticks);

    // Reset during ADD T3.
    run    = 1'b1;
    opcode = 4'd2;
    reset  = 1'b1;
    cyc();
    reset = 1'b0;
    do_tick("radd.t0", 3, 3'd0, 16'h000A);
    do_tick("radd.t1", 4, 3'd1, 16'h0064);
    do_tick("radd.t2", 4, 3'd2, 16'h0088);
    cyc();
    check("radd.in_t3", {29'd0, step}, 32'd3);
    check("radd.t3ctrl", {16'd0, ctrl}, 32'h0420);
    reset = 1'b1;
    cyc();
    check("radd.rst_step", {29'd0, step}, 32'd0);
    check("radd.rst_ctrl", {16'd0, ctrl}, 32'h000A);
    check("radd.rst_tick", {31'd0, tick}, 32'd0);
    reset = 1'b0;
    do_tick("radd.first", 3, 3'd0, 16'h000A);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
